// File: rtl/uart_mode_engine.sv
// rtl/uart_mode_engine.sv - UART mode engine: ID send, pattern match response, echo, TX FIFO
// Received bytes feed a display shift register and a match window in every mode.
module uart_mode_engine #(
  parameter int DISP_CHARS = 5,
  parameter int FIFO_DEPTH = 16,
  parameter int ID_LEN = 8,
  parameter logic [8*ID_LEN-1:0] ID_STR = "23001234",
  parameter int PAT_LEN = 5,
  parameter logic [8*PAT_LEN-1:0] PAT_STR = "hello",
  parameter int RESP_LEN = 4,
  parameter logic [8*RESP_LEN-1:0] RESP_STR = "OK\r\n"
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [1:0]                      mode,
  input  logic                            send_req,
  input  logic                            rx_valid,
  input  logic [7:0]                      rx_data,
  input  logic                            tx_ready,
  output logic                            tx_valid,
  output logic [7:0]                      tx_data,
  output logic [8*DISP_CHARS-1:0]         display,
  output logic [$clog2(FIFO_DEPTH):0]     fifo_level,
  output logic [7:0]                      drop_cnt,
  output logic                            busy
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int MAXLEN = (ID_LEN > RESP_LEN) ? ID_LEN : RESP_LEN;
  localparam int IW = $clog2(MAXLEN + 1);
  localparam logic [AW:0] FULL_LEVEL = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, SEND_ID, SEND_RESP} state_t;

  state_t                 state;
  logic [IW-1:0]          idx;
  logic [7:0]             mem [FIFO_DEPTH];
  logic [AW-1:0]          wr_ptr, rd_ptr;
  logic [8*PAT_LEN-1:0]   window, window_next;
  logic                   match, pop, can_push, gen_push, echo_req, echo_push, push, last_byte;
  logic [7:0]             gen_byte, push_data;

  assign tx_valid    = (fifo_level != '0);
  assign tx_data     = mem[rd_ptr];
  assign busy        = (state != IDLE);
  assign pop         = tx_valid && tx_ready;
  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign can_push    = (fifo_level != FULL_LEVEL) || pop;
  assign gen_push    = busy && can_push;
  assign echo_req    = (mode == 2'b10) && rx_valid;
  assign echo_push   = echo_req && can_push && !gen_push;
  assign push        = gen_push || echo_push;
  assign push_data   = gen_push ? gen_byte : rx_data;
  assign window_next = (window << 8) | (8*PAT_LEN)'(rx_data);
  assign match       = rx_valid && (window_next == PAT_STR);

  always_comb begin
    gen_byte  = 8'h00;
    last_byte = 1'b0;
    if (state == SEND_ID) begin
      gen_byte  = ID_STR[8*(ID_LEN-1-int'(idx)) +: 8];
      last_byte = (idx == IW'(ID_LEN-1));
    end else if (state == SEND_RESP) begin
      gen_byte  = RESP_STR[8*(RESP_LEN-1-int'(idx)) +: 8];
      last_byte = (idx == IW'(RESP_LEN-1));
    end
  end

  // Storage is not reset; clearing the pointers discards its contents.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
      drop_cnt   <= 8'd0;
      display    <= '0;
      window     <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      fifo_level <= fifo_level + 1'b1;
      else if (pop && !push) fifo_level <= fifo_level - 1'b1;
      if (echo_req && !echo_push && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
      if (rx_valid) begin
        display <= (display << 8) | (8*DISP_CHARS)'(rx_data);
        window  <= window_next;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      idx   <= '0;
    end else begin
      case (state)
        IDLE: begin
          idx <= '0;
          if (send_req && mode == 2'b00)   state <= SEND_ID;
          else if (match && mode == 2'b01) state <= SEND_RESP;
        end
        SEND_ID, SEND_RESP: begin
          if (gen_push) begin
            idx <= idx + 1'b1;
            if (last_byte) state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_mode_engine.sv
// tb/tb_uart_mode_engine.sv - randomized bench for uart_mode_engine against a queue-based reference model
module tb_uart_mode_engine;

  localparam int DISP = 5;
  localparam int DEPTH = 16;
  localparam logic [63:0] ID_V = "23001234";
  localparam logic [39:0] PAT_V = "hello";
  localparam logic [31:0] RESP_V = "OK\r\n";

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [1:0]  mode = 2'b11;
  logic        send_req = 1'b0;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        tx_ready = 1'b0;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic [39:0] display;
  logic [4:0]  fifo_level;
  logic [7:0]  drop_cnt;
  logic        busy;

  uart_mode_engine dut (
    .clk(clk), .rst(rst), .mode(mode), .send_req(send_req), .rx_valid(rx_valid),
    .rx_data(rx_data), .tx_ready(tx_ready), .tx_valid(tx_valid), .tx_data(tx_data),
    .display(display), .fifo_level(fifo_level), .drop_cnt(drop_cnt), .busy(busy)
  );

  always #5 clk = ~clk;

  int chk_cnt = 0;
  int pass_cnt = 0;
  logic [7:0] mq[$];
  logic [7:0] gq[$];
  logic [7:0] dq[$];
  logic [7:0] wq[$];
  logic [7:0] popped[$];
  logic [7:0] sent[$];
  int mdrop = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    chk_cnt++;
    if (got !== exp) $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    else pass_cnt++;
  endtask

  function automatic logic [7:0] id_byte(input int i);
    return ID_V[8*(7-i) +: 8];
  endfunction
  function automatic logic [7:0] pat_byte(input int i);
    return PAT_V[8*(4-i) +: 8];
  endfunction
  function automatic logic [7:0] resp_byte(input int i);
    return RESP_V[8*(3-i) +: 8];
  endfunction

  task automatic model_clear();
    mq.delete(); gq.delete(); dq.delete(); wq.delete();
    mdrop = 0;
    for (int i = 0; i < DISP; i++) dq.push_back(8'h00);
    for (int i = 0; i < 5; i++) wq.push_back(8'h00);
  endtask

  // One clock edge of the reference behaviour, from the inputs about to be sampled.
  task automatic model_edge();
    bit was_busy, do_pop, room, gpush, hit;
    was_busy = (gq.size() != 0);
    do_pop   = (mq.size() != 0) && tx_ready;
    room     = (mq.size() < DEPTH) || do_pop;
    gpush    = was_busy && room;
    if (do_pop) void'(mq.pop_front());
    if (gpush) mq.push_back(gq.pop_front());
    if (mode == 2'b10 && rx_valid) begin
      if (room && !gpush) mq.push_back(rx_data);
      else if (mdrop < 255) mdrop++;
    end
    hit = 1'b0;
    if (rx_valid) begin
      void'(dq.pop_front()); dq.push_back(rx_data);
      void'(wq.pop_front()); wq.push_back(rx_data);
      hit = 1'b1;
      for (int i = 0; i < 5; i++) if (wq[i] != pat_byte(i)) hit = 1'b0;
    end
    if (!was_busy) begin
      if (mode == 2'b00 && send_req) for (int i = 0; i < 8; i++) gq.push_back(id_byte(i));
      else if (mode == 2'b01 && hit) for (int i = 0; i < 4; i++) gq.push_back(resp_byte(i));
    end
  endtask

  task automatic check_all();
    logic [63:0] e;
    e = 64'd0;
    foreach (dq[i]) e = (e << 8) | 64'(dq[i]);
    chk("tx_valid", 64'(tx_valid), 64'(mq.size() != 0));
    if (mq.size() != 0) chk("tx_data", 64'(tx_data), 64'(mq[0]));
    chk("fifo_level", 64'(fifo_level), 64'(mq.size()));
    chk("busy", 64'(busy), 64'(gq.size() != 0));
    chk("drop_cnt", 64'(drop_cnt), 64'(mdrop));
    chk("display", 64'(display), e);
  endtask

  task automatic step();
    if (tx_valid && tx_ready) popped.push_back(tx_data);
    model_edge();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    model_clear();
    check_all();
    @(posedge clk);
    #1;
    rst = 1'b0;
    send_req = 1'b0;
    rx_valid = 1'b0;
  endtask

  task automatic rx(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data = b;
    step();
    rx_valid = 1'b0;
  endtask

  task automatic drain();
    tx_ready = 1'b1;
    for (int i = 0; i < 60 && (tx_valid || busy); i++) step();
    chk("drain_done", 64'(tx_valid || busy), 64'd0);
  endtask

  initial begin
    logic [7:0] b;
    int pidx, ready_pct;

    do_reset();

    // ID send with tx_ready high: contiguous bytes, then idle and empty.
    mode = 2'b00; tx_ready = 1'b1; popped.delete();
    send_req = 1'b1; step(); send_req = 1'b0;
    chk("id_busy_t1", 64'(busy), 64'd1);
    chk("id_valid_t1", 64'(tx_valid), 64'd0);
    step();
    for (int i = 0; i < 8; i++) begin
      chk("id_no_gap", 64'(tx_valid), 64'd1);
      step();
    end
    step();
    chk("id_count", 64'(popped.size()), 64'd8);
    for (int i = 0; i < 8 && i < popped.size(); i++) chk("id_byte", 64'(popped[i]), 64'(id_byte(i)));
    chk("id_busy_end", 64'(busy), 64'd0);
    chk("id_level_end", 64'(fifo_level), 64'd0);

    // Overlapping pattern stream yields two responses.
    do_reset();
    mode = 2'b01; tx_ready = 1'b1; popped.delete();
    rx("x");
    for (int r = 0; r < 2; r++) for (int i = 0; i < 5; i++) rx(pat_byte(i));
    drain();
    chk("resp_count", 64'(popped.size()), 64'd8);
    for (int i = 0; i < 8 && i < popped.size(); i++) chk("resp_byte", 64'(popped[i]), 64'(resp_byte(i % 4)));
    chk("display_hello", 64'(display), 64'h68656C6C6F);

    // Echo overflow after pointers have moved off zero.
    do_reset();
    mode = 2'b10; tx_ready = 1'b1;
    for (int i = 0; i < 3; i++) rx(8'(8'hA0 + i));
    drain();
    tx_ready = 1'b0; sent.delete(); popped.delete();
    for (int i = 0; i < 20; i++) begin
      b = 8'($urandom);
      sent.push_back(b);
      rx(b);
    end
    chk("ovf_level", 64'(fifo_level), 64'd16);
    chk("ovf_drop", 64'(drop_cnt), 64'd4);
    chk("ovf_head", 64'(tx_data), 64'(sent[0]));
    // Full FIFO with simultaneous push and pop.
    tx_ready = 1'b1;
    b = 8'h5A;
    rx(b);
    chk("full_pushpop_level", 64'(fifo_level), 64'd16);
    drain();
    chk("wrap_count", 64'(popped.size()), 64'd17);
    for (int i = 0; i < 16 && i < popped.size(); i++) chk("wrap_order", 64'(popped[i]), 64'(sent[i]));
    if (popped.size() == 17) chk("wrap_last", 64'(popped[16]), 64'(b));

    // Reset in the middle of an ID string, then a clean resend.
    do_reset();
    mode = 2'b00; tx_ready = 1'b1;
    send_req = 1'b1; step(); send_req = 1'b0;
    for (int i = 0; i < 4; i++) step();
    do_reset();
    chk("rst_txv", 64'(tx_valid), 64'd0);
    chk("rst_level", 64'(fifo_level), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    popped.delete();
    send_req = 1'b1; step(); send_req = 1'b0;
    drain();
    chk("resend_count", 64'(popped.size()), 64'd8);
    for (int i = 0; i < 8 && i < popped.size(); i++) chk("resend_byte", 64'(popped[i]), 64'(id_byte(i)));

    // Mode change mid-string does not abort it; idle mode still updates display.
    send_req = 1'b1; step(); send_req = 1'b0;
    mode = 2'b11; popped.delete();
    rx("q");
    drain();
    chk("mode_chg_count", 64'(popped.size()), 64'd8);

    // Randomized mix of modes, traffic and back-pressure.
    pidx = 0; ready_pct = 50;
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 40) == 0) mode = 2'($urandom);
      if ($urandom_range(0, 99) == 0) ready_pct = $urandom_range(0, 100);
      send_req = ($urandom_range(0, 15) == 0);
      rx_valid = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 4) != 0) begin
        rx_data = pat_byte(pidx % 5);
        pidx++;
      end else begin
        rx_data = 8'($urandom);
      end
      tx_ready = ($urandom_range(1, 100) <= ready_pct);
      if ($urandom_range(0, 1499) == 0) do_reset();
      else step();
    end
    send_req = 1'b0; rx_valid = 1'b0;
    drain();

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
